test_mode_param: RTL and testbench

//  - Parametrised successor of the fixed 2x2 low-density test-mode benchmark. Used as an OpenFPGA SVA/benchmark design.
//  - Inputs a, b pass through a delay pipeline into a ring of NUM_CELLS adder cells.
//  - Each cell feeds back from its ring neighbours and chains a carry to the next cell.
//  - Adds per-cell width, pipeline depth, clock enable, a 4-way mode control (RUN/HOLD/SHIFT/LOAD) and a saturating carry counter.
//  - Defaults (DATA_W=1, NUM_CELLS=4, PIPE_DEPTH=2, mode=RUN, en=1) are cycle-exact with the legacy 2x2 block.

---
 rtl/test_mode_pkg.sv | 16 +
 rtl/test_mode_cell.sv | 21 ++
 rtl/test_mode_param.sv | 100 ++++++++++
 tb/tb_test_mode_param.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/test_mode_pkg.sv
// Shared types and helpers for the test_mode_param ring benchmark.
package test_mode_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_HOLD  = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_t;

    // A cell sum needs one extra bit so the carry is never lost.
    function automatic int cell_w(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/test_mode_cell.sv
// Combinational ring adder cell: {cout, sum} = x + y + cin.
module test_mode_cell
    import test_mode_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    localparam int RW = cell_w(DATA_W);

    logic [RW-1:0] res;

    assign res         = RW'(x) + RW'(y) + RW'(cin);
    assign {cout, sum} = res;

endmodule

// File: rtl/test_mode_param.sv
// Delayed operands feed a ring of carry-chained adder cells, with
// RUN/HOLD/SHIFT/LOAD control and a saturating count of last-cell carries.
module test_mode_param
    import test_mode_pkg::*;
#(
    parameter int DATA_W     = 1,
    parameter int NUM_CELLS  = 4,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 8,
    parameter logic [NUM_CELLS*DATA_W-1:0] SEED = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [1:0]                    mode,
    input  logic [DATA_W-1:0]             a,
    input  logic [DATA_W-1:0]             b,
    output logic [NUM_CELLS*DATA_W-1:0]   out,
    output logic                          carry_out,
    output logic [CNT_W-1:0]              carry_cnt
);

    logic [PIPE_DEPTH-1:0][DATA_W-1:0] pa, pb;
    logic [NUM_CELLS-1:0][DATA_W-1:0]  ps, sum, cx, cy;
    logic [NUM_CELLS-1:0]              cin, cout;
    logic [DATA_W-1:0]                 pa_o, pb_o;
    mode_t                             md;

    assign md   = mode_t'(mode);
    assign pa_o = pa[PIPE_DEPTH-1];
    assign pb_o = pb[PIPE_DEPTH-1];
    assign out  = ps;

    // Cell 0 takes the delayed operands; the rest add their ring neighbours.
    // The chain ripples within one cycle, and cell 0 closes it on the LSB of the last cell.
    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
        if (i == 0) begin : g_head
            assign cx[i]  = pa_o;
            assign cy[i]  = pb_o;
            assign cin[i] = ps[NUM_CELLS-1][0];
        end else begin : g_body
            assign cx[i]  = ps[i-1];
            assign cy[i]  = ps[(i+1)%NUM_CELLS];
            assign cin[i] = cout[i-1];
        end
        test_mode_cell #(.DATA_W(DATA_W)) u_cell (
            .x   (cx[i]),
            .y   (cy[i]),
            .cin (cin[i]),
            .sum (sum[i]),
            .cout(cout[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa <= '0;
            pb <= '0;
        end else if (en && md != MODE_HOLD) begin
            pa[0] <= a;
            pb[0] <= b;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                pa[k] <= pa[k-1];
                pb[k] <= pb[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps        <= '0;
            carry_out <= 1'b0;
            carry_cnt <= '0;
        end else if (en) begin
            unique case (md)
                MODE_RUN: begin
                    ps        <= sum;
                    carry_out <= cout[NUM_CELLS-1];
                    if (cout[NUM_CELLS-1] && carry_cnt != '1)
                        carry_cnt <= carry_cnt + CNT_W'(1);
                end
                MODE_HOLD: ;
                MODE_SHIFT: begin
                    // Last cell falls off the end of the ring.
                    ps[0] <= pa_o;
                    for (int i = 1; i < NUM_CELLS; i++)
                        ps[i] <= ps[i-1];
                    carry_out <= 1'b0;
                end
                MODE_LOAD: begin
                    ps        <= SEED;
                    carry_out <= 1'b0;
                    carry_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_test_mode_param.sv
// Runs three configurations side by side against an integer reference model.
module tb_test_mode_param;
    import test_mode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [1:0]  mode = MODE_RUN;
    logic        a_n = 1'b0, b_n = 1'b0;
    logic [3:0]  a_w = 4'h0, b_w = 4'h0;

    logic [3:0]  out0, out1;
    logic [19:0] out2;
    logic        co0, co1, co2;
    logic [7:0]  cnt0, cnt2;
    logic [1:0]  cnt1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    test_mode_param #(.SEED(4'b1010)) u_def (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a_n), .b(b_n),
        .out(out0), .carry_out(co0), .carry_cnt(cnt0));

    test_mode_param #(.CNT_W(2), .SEED(4'b1111)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a_n), .b(b_n),
        .out(out1), .carry_out(co1), .carry_cnt(cnt1));

    test_mode_param #(.DATA_W(4), .NUM_CELLS(5), .PIPE_DEPTH(3), .SEED(20'hABCDE)) u_wide (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a_w), .b(b_w),
        .out(out2), .carry_out(co2), .carry_cnt(cnt2));

    // Reference model: one entry per configuration.
    int          cw[3] = '{1, 1, 4};
    int          cn[3] = '{4, 4, 5};
    int          cpd[3] = '{2, 2, 3};
    int          ccw[3] = '{8, 2, 8};
    logic [31:0] cseed[3] = '{32'hA, 32'hF, 32'hABCDE};
    int          m_ps[3][8];
    int          m_pa[3][8];
    int          m_pb[3][8];
    int          m_co[3];
    int          m_cnt[3];

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 8; i++) begin
                m_ps[c][i] = 0; m_pa[c][i] = 0; m_pb[c][i] = 0;
            end
            m_co[c] = 0; m_cnt[c] = 0;
        end
    endtask

    task automatic model_step();
        int ns[8];
        int pao, pbo, t, car, lim, ai, bi;
        if (!en) return;
        for (int c = 0; c < 3; c++) begin
            lim = 1 << cw[c];
            ai  = (c == 2) ? int'(a_w) : int'(a_n);
            bi  = (c == 2) ? int'(b_w) : int'(b_n);
            pao = m_pa[c][cpd[c]-1];
            pbo = m_pb[c][cpd[c]-1];
            t = pao + pbo + (m_ps[c][cn[c]-1] % 2);
            ns[0] = t % lim; car = t / lim;
            for (int i = 1; i < cn[c]; i++) begin
                t = m_ps[c][i-1] + m_ps[c][(i+1) % cn[c]] + car;
                ns[i] = t % lim; car = t / lim;
            end
            case (mode)
                MODE_RUN: begin
                    for (int i = 0; i < cn[c]; i++) m_ps[c][i] = ns[i];
                    m_co[c] = car;
                    if (car == 1 && m_cnt[c] < (1 << ccw[c]) - 1) m_cnt[c]++;
                end
                MODE_SHIFT: begin
                    for (int i = cn[c]-1; i > 0; i--) m_ps[c][i] = m_ps[c][i-1];
                    m_ps[c][0] = pao;
                    m_co[c] = 0;
                end
                MODE_LOAD: begin
                    for (int i = 0; i < cn[c]; i++)
                        m_ps[c][i] = int'((cseed[c] >> (i*cw[c])) & (lim - 1));
                    m_co[c] = 0; m_cnt[c] = 0;
                end
                default: ;
            endcase
            if (mode != MODE_HOLD) begin
                for (int k = cpd[c]-1; k > 0; k--) begin
                    m_pa[c][k] = m_pa[c][k-1]; m_pb[c][k] = m_pb[c][k-1];
                end
                m_pa[c][0] = ai; m_pb[c][0] = bi;
            end
        end
    endtask

    function automatic logic [31:0] model_out(int c);
        logic [31:0] v = '0;
        for (int i = 0; i < cn[c]; i++) v |= 32'(m_ps[c][i]) << (i*cw[c]);
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, " out0"}, 32'(out0), model_out(0));
        chk({tag, " co0"},  32'(co0),  32'(m_co[0]));
        chk({tag, " cnt0"}, 32'(cnt0), 32'(m_cnt[0]));
        chk({tag, " out1"}, 32'(out1), model_out(1));
        chk({tag, " co1"},  32'(co1),  32'(m_co[1]));
        chk({tag, " cnt1"}, 32'(cnt1), 32'(m_cnt[1]));
        chk({tag, " out2"}, 32'(out2), model_out(2));
        chk({tag, " co2"},  32'(co2),  32'(m_co[2]));
        chk({tag, " cnt2"}, 32'(cnt2), 32'(m_cnt[2]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        #1;
    endtask

    task automatic rand_ab();
        a_n = 1'($urandom); b_n = 1'($urandom);
        a_w = 4'($urandom); b_w = 4'($urandom);
    endtask

    logic [31:0] snap0, snap2;

    initial begin
        model_reset();
        // Reset state
        tick(); tick();
        check_all("reset");
        rst_n = 1'b1;

        // First-transaction latency
        a_n = 1'b1; b_n = 1'b0; a_w = 4'hF; b_w = 4'hF; mode = MODE_RUN;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check_all("lat");
            if (e == 3) chk("edge3 out0", 32'(out0), 32'b0001);
            if (e == 4) begin
                chk("edge4 out0", 32'(out0), 32'b1011);
                chk("edge4 wide cell0", 32'(out2[3:0]), 32'hE);
            end
        end

        // Random RUN
        for (int n = 0; n < 1000; n++) begin
            rand_ab(); tick(); check_all("run");
        end

        // HOLD pauses everything, then resumes
        snap0 = model_out(0); snap2 = model_out(2);
        mode = MODE_HOLD;
        for (int n = 0; n < 5; n++) begin
            rand_ab(); tick(); check_all("hold");
            chk("hold out0 frozen", 32'(out0), snap0);
            chk("hold out2 frozen", 32'(out2), snap2);
        end
        mode = MODE_RUN;
        for (int n = 0; n < 20; n++) begin
            rand_ab(); tick(); check_all("resume");
        end

        // LOAD then SHIFT zeros in
        a_n = 0; b_n = 0; a_w = 0; b_w = 0;
        for (int n = 0; n < 3; n++) begin tick(); check_all("flush"); end
        mode = MODE_LOAD; tick(); check_all("load");
        chk("load out0", 32'(out0), 32'b1010);
        chk("load cnt0", 32'(cnt0), 32'd0);
        chk("load out2", 32'(out2), 32'hABCDE);
        mode = MODE_SHIFT;
        tick(); check_all("shift"); chk("shift1 out0", 32'(out0), 32'b0100);
        tick(); check_all("shift"); chk("shift2 out0", 32'(out0), 32'b1000);
        tick(); check_all("shift"); chk("shift3 out0", 32'(out0), 32'b0000);

        // Clock enable low freezes every mode
        mode = MODE_RUN; a_n = 1; a_w = 4'h9;
        for (int n = 0; n < 4; n++) tick();
        check_all("pre-en");
        snap0 = model_out(0); snap2 = model_out(2);
        en = 1'b0;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            for (int n = 0; n < 3; n++) begin
                rand_ab(); tick(); check_all("en0");
                chk("en0 out0 frozen", 32'(out0), snap0);
                chk("en0 out2 frozen", 32'(out2), snap2);
            end
        end
        en = 1'b1;

        // Saturation on the 2-bit counter: all-ones ring with 1+1 operands carries every edge
        mode = MODE_RUN; a_n = 1; b_n = 1; a_w = 4'h1; b_w = 4'h2;
        tick(); check_all("sat prep"); tick(); check_all("sat prep");
        mode = MODE_LOAD; tick(); check_all("sat load");
        chk("sat load cnt1", 32'(cnt1), 32'd0);
        mode = MODE_RUN;
        for (int n = 1; n <= 4; n++) begin
            tick(); check_all("sat");
            chk("sat cnt1", 32'(cnt1), 32'((n > 3) ? 3 : n));
        end

        // Asynchronous reset mid-run
        for (int n = 0; n < 10; n++) begin rand_ab(); tick(); check_all("prerst"); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async out0", 32'(out0), 32'd0);
        chk("async out2", 32'(out2), 32'd0);
        chk("async co0", 32'(co0), 32'd0);
        chk("async cnt0", 32'(cnt0), 32'd0);
        check_all("async");
        #1 rst_n = 1'b1;
        for (int n = 0; n < 30; n++) begin rand_ab(); tick(); check_all("post"); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
